be_clock_sequencer: RTL and testbench
=====================================

Name: be_clock_sequencer

Overview:
Clock controller for the 8-bit computer. It sequences the CPU clock between continuous run, manual single-step and halt. It replaces free-running toggling with an explicit state machine that:
- debounces the step button
- stops the clock only on a low phase
- emits one-iCLK-cycle CLK_RISE/CLK_FALL enables so downstream CPU logic can run on iCLK with clock enables.

Parameters:
CLK_HZ, 50000000, iCLK frequency; base half-period = CLK_HZ/2 iCLK cycles (1 Hz CPU clock)
DEBOUNCE_CYCLES, 500000, cycles CLK_STEP must be stable before accepted (10 ms at 50 MHz)
STEP_HIGH_CYCLES, 1000, iCLK cycles CLK stays high for one manual step
CNT_W, 26, half-period / debounce counter width

Ports:
iCLK  in  1  board clock; all logic on posedge
iRST  in  1  synchronous, active-high reset
CLK_SELECT  in  1  async switch; 0 = continuous, 1 = manual step
CLK_STEP  in  1  async raw step button, active high
HLT_N  in  1  async halt button, active low
CPU_HLT  in  1  synchronous halt request from CPU control logic (HLT instruction), active high
DIV_CLK  in  3  speed select; half-period = max(1, (CLK_HZ/2) >> DIV_CLK)
CLK  out  1  CPU clock level, registered
NOT_CLK  out  1  always ~CLK, registered in the same cycle
CLK_RISE  out  1  one-cycle pulse, high in the first iCLK cycle where CLK=1
CLK_FALL  out  1  one-cycle pulse, high in the first iCLK cycle where CLK=0
HALTED  out  1  high while in HALT state

Behaviour:
- Reset values:
  - Outputs: CLK=0, NOT_CLK=1, CLK_RISE=0, CLK_FALL=0, HALTED=0.
  - State IDLE, counters 0, latched half-period = DIV_CLK=0 value.
  - Synchronizers and debounce cleared to released/not-halted.
- Input conditioning:
  - CLK_SELECT, HLT_N, CLK_STEP pass through 2-FF synchronizers.
  - CLK_STEP is then debounced: the level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - A 0->1 transition of the accepted level gives step_pulse (1 cycle).
  - halt_req = ~HLT_N_sync | CPU_HLT.
- States: IDLE, RUN, STEP_HI, HALT. CLK=0 in IDLE and HALT.
- IDLE, priority order:
  - halt_req -> HALT.
  - else CLK_SELECT_sync=0 -> RUN: counter=0, half-period latched from DIV_CLK; CLK stays low for one half-period, then rises.
  - else step_pulse -> STEP_HI: CLK=1 and CLK_RISE=1 in the next cycle.
- RUN:
  - Counter increments each cycle.
  - At counter == half_period-1: toggle CLK, counter=0, re-latch DIV_CLK. A DIV_CLK change never cuts a phase short.
  - Toggle 0->1 raises CLK_RISE; toggle 1->0 raises CLK_FALL.
  - On a falling toggle with halt_req=1 -> HALT. Else with CLK_SELECT_sync=1 -> IDLE.
  - halt_req or a mode change while CLK=1 waits for the high phase to complete; CLK is never truncated.
- STEP_HI:
  - CLK high for exactly STEP_HIGH_CYCLES cycles, then falls (CLK_FALL) -> IDLE.
  - step_pulse, halt_req and mode change are ignored during STEP_HI. Halt is evaluated in IDLE afterwards.
- HALT:
  - CLK held low, HALTED=1.
  - Exit to IDLE when halt_req=0. HALTED drops in the same cycle as the state change.
  - Step presses during HALT are discarded, not queued.
- Latency: step press held stable -> CLK rise exactly DEBOUNCE_CYCLES+4 iCLK cycles after the first sampling edge of raw CLK_STEP=1.
- iRST mid-operation: returns to reset values in the next cycle, including CLK=0 mid-high-phase. No CLK_FALL pulse is emitted for a reset-forced fall.
- Invariants:
  - CLK_RISE and CLK_FALL are never both high.
  - NOT_CLK == ~CLK every cycle.

Optional Feature:
BE_CYCLE_COUNT_EN:
- When defined: adds output CYCLE_COUNT[15:0].
  - Increments on every CLK_RISE, wraps 16'hFFFF -> 0.
  - Cleared by iRST; holds value through HALT.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package be_clock_pkg:
  - state enum (IDLE, RUN, STEP_HI, HALT)
  - CNT_W default
  - function half_period(CLK_HZ, DIV_CLK) with min-1 clamp
- One sub-module, be_debounce: 2-FF sync + stable counter + rising-edge pulse, parameter DEBOUNCE_CYCLES. Instantiated for CLK_STEP only.

Test Plan (CLK_HZ=16, DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=2):
- Reset: iRST=1 for 3 cycles -> CLK=0, NOT_CLK=1, HALTED=0, no pulses. Release with CLK_SELECT=0, DIV_CLK=0 -> CLK toggles every 8 cycles, one CLK_RISE per 16 cycles.
- Speed change: DIV_CLK 0->3 mid high phase -> current phase completes at 8 cycles, subsequent phases 1 cycle. DIV_CLK=7 -> clamp to 1-cycle phases.
- Manual step: CLK_SELECT=1, CLK_STEP high 10 cycles -> exactly one CLK high pulse of 2 cycles, CLK_RISE 8 cycles after first sampled high. A 2-cycle bounce glitch -> no pulse.
- Halt in high phase: CPU_HLT=1 while CLK=1 in RUN -> high phase finishes, CLK_FALL, HALTED=1 next cycle, CLK low. CPU_HLT=0 -> IDLE then RUN resumes.
- HLT_N=0 during STEP_HI -> step completes (2 cycles high), then HALT. Step presses while HALTED produce no CLK_RISE.
- iRST asserted while CLK=1 in RUN -> CLK=0 next cycle, no CLK_FALL. With BE_CYCLE_COUNT_EN: 3 steps -> CYCLE_COUNT=3, reset -> 0.

Source files
------------

// File: rtl/be_clock_pkg.sv
// Shared types and helpers for the 8-bit computer clock sequencer.
package be_clock_pkg;

  localparam int CNT_W_DEFAULT = 26;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_HI,
    HALT
  } seq_state_e;

  // Conditioned, clock-domain-safe control inputs seen by the sequencer FSM.
  typedef struct packed {
    logic sel;
    logic halt_req;
    logic step_pulse;
  } seq_in_t;

  // Half-period in iCLK cycles for a speed select, never below one cycle.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input logic [2:0]  div);
    int unsigned h;
    h = (clk_hz / 2) >> div;
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/be_debounce.sv
// 2-FF synchronizer, stable-level debouncer and registered rising-edge pulse.
module be_debounce
  import be_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = CNT_W_DEFAULT
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic raw,
  output logic pulse
);

  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // A new level is taken on the first differing sample followed by
  // DEBOUNCE_CYCLES more samples that still differ from the accepted level.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      pulse   <= level & ~level_d;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/be_clock_sequencer.sv
// CPU clock sequencer: continuous run, manual single-step and halt, with
// one-cycle CLK_RISE/CLK_FALL enables. Define BE_CYCLE_COUNT_EN to add CYCLE_COUNT.
module be_clock_sequencer
  import be_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned STEP_HIGH_CYCLES = 1000,
  parameter int          CNT_W            = CNT_W_DEFAULT
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       CLK_SELECT,
  input  logic       CLK_STEP,
  input  logic       HLT_N,
  input  logic       CPU_HLT,
  input  logic [2:0] DIV_CLK,
  output logic       CLK,
  output logic       NOT_CLK,
  output logic       CLK_RISE,
  output logic       CLK_FALL,
  output logic       HALTED
`ifdef BE_CYCLE_COUNT_EN
  ,
  output logic [15:0] CYCLE_COUNT
`endif
);

  typedef struct packed {
    seq_state_e       state;
    logic             clk;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
  } seq_regs_t;

  seq_regs_t  r, r_n;
  seq_in_t    cin;
  logic [1:0] sel_sync;
  logic [1:0] hltn_sync;
  logic       step_pulse;
  logic       not_clk_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sel_sync  <= 2'b00;
      hltn_sync <= 2'b11;
    end else begin
      sel_sync  <= {sel_sync[0], CLK_SELECT};
      hltn_sync <= {hltn_sync[0], HLT_N};
    end
  end

  be_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_db (
    .iCLK (iCLK),
    .iRST (iRST),
    .raw  (CLK_STEP),
    .pulse(step_pulse)
  );

  assign cin.sel        = sel_sync[1];
  assign cin.halt_req   = ~hltn_sync[1] | CPU_HLT;
  assign cin.step_pulse = step_pulse;

  always_comb begin
    r_n      = r;
    r_n.rise = 1'b0;
    r_n.fall = 1'b0;
    case (r.state)
      IDLE: begin
        r_n.clk = 1'b0;
        if (cin.halt_req) begin
          r_n.state = HALT;
        end else if (!cin.sel) begin
          r_n.state = RUN;
          r_n.cnt   = '0;
          r_n.half  = CNT_W'(half_period(CLK_HZ, DIV_CLK));
        end else if (cin.step_pulse) begin
          r_n.state = STEP_HI;
          r_n.clk   = 1'b1;
          r_n.rise  = 1'b1;
          r_n.cnt   = '0;
        end
      end
      RUN: begin
        if (r.cnt == r.half - CNT_W'(1)) begin
          // Speed changes only take effect at a phase boundary.
          r_n.clk  = ~r.clk;
          r_n.cnt  = '0;
          r_n.half = CNT_W'(half_period(CLK_HZ, DIV_CLK));
          if (!r.clk) begin
            r_n.rise = 1'b1;
          end else begin
            r_n.fall = 1'b1;
            if (cin.halt_req)  r_n.state = HALT;
            else if (cin.sel)  r_n.state = IDLE;
          end
        end else begin
          r_n.cnt = r.cnt + CNT_W'(1);
        end
      end
      STEP_HI: begin
        if (r.cnt == CNT_W'(STEP_HIGH_CYCLES - 1)) begin
          r_n.clk   = 1'b0;
          r_n.fall  = 1'b1;
          r_n.cnt   = '0;
          r_n.state = IDLE;
        end else begin
          r_n.cnt = r.cnt + CNT_W'(1);
        end
      end
      HALT: begin
        r_n.clk = 1'b0;
        if (!cin.halt_req) r_n.state = IDLE;
      end
      default: begin
        r_n.state = IDLE;
        r_n.clk   = 1'b0;
      end
    endcase
  end

  // Reset drops CLK directly; no CLK_FALL is generated for it.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r.state   <= IDLE;
      r.clk     <= 1'b0;
      r.rise    <= 1'b0;
      r.fall    <= 1'b0;
      r.cnt     <= '0;
      r.half    <= CNT_W'(half_period(CLK_HZ, 3'd0));
      not_clk_q <= 1'b1;
    end else begin
      r         <= r_n;
      not_clk_q <= ~r_n.clk;
    end
  end

  assign CLK      = r.clk;
  assign NOT_CLK  = not_clk_q;
  assign CLK_RISE = r.rise;
  assign CLK_FALL = r.fall;
  assign HALTED   = (r.state == HALT);

`ifdef BE_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge iCLK) begin
    if (iRST)          cyc_q <= '0;
    else if (r_n.rise) cyc_q <= cyc_q + 16'd1;
  end

  assign CYCLE_COUNT = cyc_q;
`endif

endmodule

// File: tb/tb_be_clock_sequencer.sv
// Self-checking bench for be_clock_sequencer: directed steps plus randomized
// speed changes and step presses against a phase-length / press-length model.
module tb_be_clock_sequencer;

  localparam int HZ = 16;
  localparam int DB = 4;
  localparam int SH = 2;

  logic       iCLK = 1'b0;
  logic       iRST, CLK_SELECT, CLK_STEP, HLT_N, CPU_HLT;
  logic [2:0] DIV_CLK;
  logic       CLK, NOT_CLK, CLK_RISE, CLK_FALL, HALTED;
`ifdef BE_CYCLE_COUNT_EN
  logic [15:0] CYCLE_COUNT;
`endif

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic prev_clk = 1'b0;
  logic rst_q = 1'b1;
  int   rise_cnt = 0;
  int   rise_since_rst = 0;

  always #5 iCLK = ~iCLK;

  be_clock_sequencer #(
    .CLK_HZ          (HZ),
    .DEBOUNCE_CYCLES (DB),
    .STEP_HIGH_CYCLES(SH),
    .CNT_W           (26)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .CLK_SELECT (CLK_SELECT),
    .CLK_STEP   (CLK_STEP),
    .HLT_N      (HLT_N),
    .CPU_HLT    (CPU_HLT),
    .DIV_CLK    (DIV_CLK),
    .CLK        (CLK),
    .NOT_CLK    (NOT_CLK),
    .CLK_RISE   (CLK_RISE),
    .CLK_FALL   (CLK_FALL),
    .HALTED     (HALTED)
`ifdef BE_CYCLE_COUNT_EN
    ,
    .CYCLE_COUNT(CYCLE_COUNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hp_ref(input int d);
    int h;
    h = (HZ / 2) >> d;
    return (h < 1) ? 1 : h;
  endfunction

  // Waits (bounded) for CLK to reach lvl; n = negedges spent waiting.
  task automatic wait_clk(input logic lvl, input int budget, output int n);
    n = 0;
    while (CLK !== lvl && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    chk("wait_clk_lvl", CLK, lvl);
  endtask

  // Holds CLK_STEP for L sampling edges, observes win cycles.
  task automatic press(input int L, input int win, output int r, output int at, output int hi);
    r = 0; at = -1; hi = 0;
    CLK_STEP = (L > 0);
    for (int i = 1; i <= win; i++) begin
      @(negedge iCLK);
      if (i == L) CLK_STEP = 1'b0;
      if (CLK_RISE) begin
        r++;
        if (at < 0) at = i;
      end
      if (CLK) hi++;
    end
    CLK_STEP = 1'b0;
  endtask

  always @(posedge iCLK) rst_q <= iRST;

  // Pulse definitions: RISE marks the first CLK=1 cycle, FALL the first CLK=0
  // cycle unless the fall was forced by reset.
  always @(negedge iCLK) begin
    if (mon_en) begin
      chk("not_clk", NOT_CLK, !CLK);
      chk("rise_pulse", CLK_RISE, CLK && !prev_clk && !rst_q);
      chk("fall_pulse", CLK_FALL, !CLK && prev_clk && !rst_q);
      if (rst_q) rise_since_rst = 0;
      else if (CLK_RISE) rise_since_rst++;
`ifdef BE_CYCLE_COUNT_EN
      chk("cycle_count", CYCLE_COUNT, rise_since_rst[15:0]);
`endif
      if (CLK_RISE) rise_cnt++;
      prev_clk = CLK;
    end
  end

  initial begin
    int   n, r, at, hi, L, d_edge, run, exp_len, r0;
    logic prev;
    bit   have, lng;

    iRST = 1'b1; CLK_SELECT = 1'b0; CLK_STEP = 1'b0;
    HLT_N = 1'b1; CPU_HLT = 1'b0; DIV_CLK = 3'd0;
    @(negedge iCLK);
    mon_en = 1'b1;
    repeat (2) @(negedge iCLK);
    chk("rst_clk", CLK, 0);
    chk("rst_not_clk", NOT_CLK, 1);
    chk("rst_halted", HALTED, 0);
    chk("rst_rise", CLK_RISE, 0);
    chk("rst_fall", CLK_FALL, 0);

    // Continuous run at DIV_CLK=0: 8-cycle phases.
    iRST = 1'b0;
    wait_clk(1'b1, 40, n); chk("first_rise_lat", n, 1 + hp_ref(0));
    wait_clk(1'b0, 20, n); chk("half_hi", n, 8);
    wait_clk(1'b1, 20, n); chk("half_lo", n, 8);
    wait_clk(1'b0, 20, n); chk("half_hi2", n, 8);
    r0 = rise_cnt;
    repeat (32) @(negedge iCLK);
    chk("rises_per_32", rise_cnt - r0, 2);

    // Speed change mid high phase completes the current phase first.
    wait_clk(1'b1, 20, n); chk("half_lo2", n, 8);
    repeat (3) @(negedge iCLK);
    DIV_CLK = 3'd3;
    wait_clk(1'b0, 20, n); chk("phase_not_cut", n, 5);
    wait_clk(1'b1, 20, n); chk("div3_lo", n, 1);
    wait_clk(1'b0, 20, n); chk("div3_hi", n, 1);
    DIV_CLK = 3'd7;
    wait_clk(1'b1, 20, n); chk("div7_lo", n, 1);
    wait_clk(1'b0, 20, n); chk("div7_hi", n, 1);

    // Random speed changes: each phase length follows DIV_CLK at its start.
    prev = CLK; run = 0; have = 1'b0; exp_len = 0;
    repeat (300) begin
      d_edge = int'(DIV_CLK);
      @(negedge iCLK);
      if (CLK !== prev) begin
        if (have) chk("rand_phase_len", run, exp_len);
        have = 1'b1;
        exp_len = hp_ref(d_edge);
        run = 1;
        prev = CLK;
      end else begin
        run++;
      end
      if ($urandom_range(0, 7) == 0) DIV_CLK = 3'($urandom_range(0, 7));
    end
    DIV_CLK = 3'd0;

    // Manual mode: clock parks low, steps only on debounced presses.
    CLK_SELECT = 1'b1;
    repeat (40) @(negedge iCLK);
    chk("manual_idle_clk", CLK, 0);
    r0 = rise_cnt;
    repeat (20) @(negedge iCLK);
    chk("manual_no_rise", rise_cnt - r0, 0);

    press(10, 30, r, at, hi);
    chk("step_rises", r, 1);
    chk("step_rise_lat", at, DB + 5);
    chk("step_hi_len", hi, SH);
    press(2, 20, r, at, hi);
    chk("glitch_rises", r, 0);
    chk("glitch_hi", hi, 0);

    repeat (6) begin
      lng = 1'($urandom_range(0, 1));
      L = lng ? $urandom_range(DB + 3, 12) : $urandom_range(1, 3);
      press(L, 30, r, at, hi);
      chk("rand_step_rises", r, lng);
      if (lng) chk("rand_step_lat", at, DB + 5);
      chk("rand_step_hi", hi, lng ? SH : 0);
    end

    // CPU halt during a high phase: phase completes, then HALT.
    CLK_SELECT = 1'b0;
    wait_clk(1'b1, 40, n);
    repeat (2) @(negedge iCLK);
    CPU_HLT = 1'b1;
    wait_clk(1'b0, 20, n); chk("halt_hi_rest", n, 6);
    chk("halt_fall", CLK_FALL, 1);
    chk("halt_halted", HALTED, 1);
    r0 = rise_cnt;
    repeat (10) @(negedge iCLK);
    chk("halt_clk_low", CLK, 0);
    chk("halt_held", HALTED, 1);
    chk("halt_no_rise", rise_cnt - r0, 0);
    CPU_HLT = 1'b0;
    @(negedge iCLK);
    chk("unhalt_halted", HALTED, 0);
    chk("unhalt_clk", CLK, 0);
    wait_clk(1'b1, 40, n); chk("resume_lat", n, 1 + hp_ref(0));

    // HLT_N during a manual step: step finishes, then HALT; presses discarded.
    CLK_SELECT = 1'b1;
    repeat (40) @(negedge iCLK);
    CLK_STEP = 1'b1;
    wait_clk(1'b1, 20, n); chk("step2_lat", n, DB + 5);
    HLT_N = 1'b0;
    CLK_STEP = 1'b0;
    hi = 1;
    repeat (10) begin
      @(negedge iCLK);
      if (CLK) hi++;
    end
    chk("step_hlt_hi", hi, SH);
    chk("step_hlt_halted", HALTED, 1);
    press(8, 30, r, at, hi);
    chk("halted_press_rises", r, 0);
    chk("halted_press_hi", hi, 0);
    chk("halted_still", HALTED, 1);
    HLT_N = 1'b1;
    press(0, 30, r, at, hi);
    chk("no_queued_step", r, 0);
    chk("hltn_release", HALTED, 0);

    // Reset in the middle of a high phase.
    CLK_SELECT = 1'b0;
    wait_clk(1'b1, 40, n);
    repeat (2) @(negedge iCLK);
    chk("pre_rst_hi", CLK, 1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("midrst_clk", CLK, 0);
    chk("midrst_not_clk", NOT_CLK, 1);
    chk("midrst_fall", CLK_FALL, 0);
    chk("midrst_halted", HALTED, 0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
